// File: rtl/ram_responder_with_scan_pkg.sv
// Shared widths, FSM state type and parity-bit width for the RAM responder.
// RAM_PARITY_EN adds one stored even-parity bit per word.
package ram_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

`ifdef RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_responder_with_scan_ram_array.sv
// Storage array for the RAM responder: one synchronous write port and one
// combinational read port. Contents are not reset; the top-level clear handles that.
module ram_array_256x8 #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder_with_scan.sv
// 256x8 RAM responder: post-reset clear engine, write-first bypass, registered
// read data that doubles as a scan chain. RAM_PARITY_EN adds stored parity and parity_err.
module ram_responder_with_scan
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ren_wen,
    input  logic [ADDR_W-1:0] ram_write_addr,
    input  logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              init_busy,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int WORD_W = DATA_W + PAR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              clearing;
    logic              func_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic              bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Scan shifting freezes the clear sequence in place.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clearing   = 1'b0;
        if (state == CLEAR && !scan_en) begin
            clearing = 1'b1;
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state_next = READY;
            end
        end
    end

    assign func_we   = (state == READY) && mem_ren_wen && !scan_en;
    assign arr_we    = func_we || clearing;
    assign arr_waddr = clearing ? cnt : ram_write_addr;
    assign bypass    = func_we && (ram_read_addr == ram_write_addr);
    assign init_busy = (state == CLEAR);
    assign scan_out  = ram_data_out[0];

`ifdef RAM_PARITY_EN
    assign arr_wdata = clearing ? '0 : {^ram_data_in, ram_data_in};
`else
    assign arr_wdata = clearing ? '0 : ram_data_in;
`endif

    ram_array_256x8 #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .raddr(ram_read_addr),
        .rdata(arr_rdata)
    );

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_data_out <= '0;
            parity_err   <= 1'b0;
        end else if (scan_en) begin
            parity_err   <= scan_in;
            ram_data_out <= {parity_err, ram_data_out[DATA_W-1:1]};
        end else if (state == CLEAR) begin
            ram_data_out <= '0;
            parity_err   <= 1'b0;
        end else if (bypass) begin
            ram_data_out <= ram_data_in;
            parity_err   <= 1'b0;
        end else begin
            ram_data_out <= arr_rdata[DATA_W-1:0];
            parity_err   <= ^arr_rdata;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_data_out <= '0;
        end else if (scan_en) begin
            ram_data_out <= {scan_in, ram_data_out[DATA_W-1:1]};
        end else if (state == CLEAR) begin
            ram_data_out <= '0;
        end else if (bypass) begin
            ram_data_out <= ram_data_in;
        end else begin
            ram_data_out <= arr_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder_with_scan.sv
// Bench for ram_responder_with_scan: directed plus random traffic against an
// array-based reference model of the RAM. Define RAM_PARITY_EN to cover parity.
module tb_ram_responder_with_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ren_wen;
    logic [7:0] ram_write_addr;
    logic [7:0] ram_read_addr;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;
    logic       init_busy;
    logic       scan_en;
    logic       scan_in;
    logic       scan_out;
`ifdef RAM_PARITY_EN
    logic       parity_err;
    localparam int CHAIN = 9;
`else
    localparam int CHAIN = 8;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model [256];

    ram_responder_with_scan dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ren_wen   (mem_ren_wen),
        .ram_write_addr(ram_write_addr),
        .ram_read_addr (ram_read_addr),
        .ram_data_in   (ram_data_in),
        .ram_data_out  (ram_data_out),
        .init_busy     (init_busy),
        .scan_en       (scan_en),
        .scan_in       (scan_in),
        .scan_out      (scan_out)
`ifdef RAM_PARITY_EN
        ,
        .parity_err    (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One READY-mode cycle: model a write-first RAM with registered read.
    task automatic step(input logic we, input logic [7:0] wa, input logic [7:0] ra,
                        input logic [7:0] wd, input string tag);
        logic [7:0] exp;
        mem_ren_wen    = we;
        ram_write_addr = wa;
        ram_read_addr  = ra;
        ram_data_in    = wd;
        scan_en        = 1'b0;
        @(posedge clk);
        exp = (we && wa == ra) ? wd : model[ra];
        if (we) model[wa] = wd;
        #1;
        check(tag, ram_data_out, exp);
        mem_ren_wen = 1'b0;
    endtask

    task automatic shift(input logic b);
        scan_en = 1'b1;
        scan_in = b;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_busy drops, bounded so a stuck FSM cannot hang.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!init_busy) break;
        end
    endtask

    initial begin
        int n;
        logic [7:0] pattern;
        logic [7:0] wa, ra;

        rst = 1'b1;
        mem_ren_wen = 1'b0;
        ram_write_addr = '0;
        ram_read_addr = '0;
        ram_data_in = '0;
        scan_en = 1'b0;
        scan_in = 1'b0;
        #12;
        check("reset_data_out", ram_data_out, 0);
        check("reset_init_busy", init_busy, 1);
        check("reset_scan_out", scan_out, 0);
`ifdef RAM_PARITY_EN
        check("reset_parity_err", parity_err, 0);
`endif

        // Clear with a functional write attempt that must be ignored.
        @(negedge clk);
        rst = 1'b0;
        mem_ren_wen = 1'b1;
        ram_write_addr = 8'h05;
        ram_data_in = 8'hFF;
        wait_ready(n);
        mem_ren_wen = 1'b0;
        check("clear_edges", n, 256);
        check("clear_data_out", ram_data_out, 0);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        step(0, 8'h00, 8'h00, 8'h00, "read_0x00");
        step(0, 8'h00, 8'h7F, 8'h00, "read_0x7F");
        step(0, 8'h00, 8'hFF, 8'h00, "read_0xFF");
        step(0, 8'h00, 8'h05, 8'h00, "write_in_clear_ignored");

        step(1, 8'h3C, 8'h00, 8'hA5, "write_a5");
        step(0, 8'h00, 8'h3C, 8'h00, "read_a5");
        check("read_a5_const", ram_data_out, 8'hA5);
        step(1, 8'h10, 8'h10, 8'h5A, "bypass_5a");
        check("bypass_5a_const", ram_data_out, 8'h5A);
        step(0, 8'h00, 8'h10, 8'h00, "after_bypass");

        for (int i = 0; i < 200; i++) begin
            wa = 8'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, ra, 8'($urandom), "random");
`ifdef RAM_PARITY_EN
            check("random_parity", parity_err, 0);
`endif
        end

        // Scan: load 0xC3, then shift it back out while a write is attempted.
        step(0, 8'h00, 8'hFF, 8'h00, "pre_scan_zero");
        pattern = 8'hC3;
        for (int i = 0; i < CHAIN; i++) shift((i < 8) ? pattern[i] : 1'b0);
        check("scan_load", ram_data_out, 8'hC3);
        mem_ren_wen = 1'b1;
        ram_write_addr = 8'h3C;
        ram_data_in = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("scan_out_%0d", i), scan_out, pattern[i]);
            shift(1'b0);
        end
        mem_ren_wen = 1'b0;
        step(0, 8'h00, 8'h3C, 8'h00, "scan_write_suppressed");
        for (int i = 0; i < 32; i++) step(0, 8'h00, 8'(i), 8'h00, "post_scan_contents");

`ifdef RAM_PARITY_EN
        step(1, 8'h20, 8'h00, 8'h07, "par_write_07");
        dut.u_array.mem[8'h20][8] = ~dut.u_array.mem[8'h20][8];
        step(0, 8'h00, 8'h20, 8'h00, "par_read_07");
        check("par_err_flipped", parity_err, 1);
        step(1, 8'h21, 8'h00, 8'h03, "par_write_03");
        step(0, 8'h00, 8'h21, 8'h00, "par_read_03");
        check("par_err_clean", parity_err, 0);
`endif

        // Asynchronous reset mid-operation, then a clear paused by scan_en.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midreset_data_out", ram_data_out, 0);
        check("midreset_init_busy", init_busy, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) @(posedge clk);
        #1;
        scan_en = 1'b1;
        for (int i = 0; i < 7; i++) @(posedge clk);
        #1;
        check("pause_busy", init_busy, 1);
        scan_en = 1'b0;
        wait_ready(n);
        check("resume_edges", n, 156);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        step(0, 8'h00, 8'h3C, 8'h00, "recleared_0x3C");
        step(0, 8'h00, 8'h10, 8'h00, "recleared_0x10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
